// File: rtl/rot_pkg.sv
// rot_pkg: shared state encoding and default width for the rotation-amount finder.
package rot_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} rot_find_state_t;
  localparam int ROT_DEFAULT_WIDTH = 4;
endpackage

// File: rtl/rot_step.sv
// rot_step: single-bit left and right rotation of a word.
module rot_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] rotl1,
  output logic [WIDTH-1:0] rotr1
);
  assign rotl1 = {word[WIDTH-2:0], word[WIDTH-1]};
  assign rotr1 = {word[0], word[WIDTH-1:1]};
endmodule

// File: rtl/rot_amount_finder.sv
// rot_amount_finder: sequential search for the rotation mapping orig onto rotated.
// Define ROT_FIND_BIDIR_EN to search left and right paths in parallel.
module rot_amount_finder
  import rot_pkg::*;
#(
  parameter int WIDTH = ROT_DEFAULT_WIDTH,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] orig,
  input  logic [WIDTH-1:0] rotated,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             found,
  output logic             dir,
  output logic [SHW-1:0]   shamt,
  output logic [SHW-1:0]   shamt_left
);
  rot_find_state_t state_q, state_d;
  logic [WIDTH-1:0] work_l_q, work_l_d, target_q, target_d, step_l, unused_rotr;
  logic [SHW-1:0] k_q, k_d, shamt_q, shamt_d, shl_q, shl_d;
  logic found_q, found_d, hit_l;
  rot_step #(.WIDTH(WIDTH)) u_step_l (.word(work_l_q), .rotl1(step_l), .rotr1(unused_rotr));
  assign hit_l = work_l_q == target_q;
`ifdef ROT_FIND_BIDIR_EN
  localparam logic [SHW-1:0] K_LAST = SHW'(WIDTH / 2);
  logic [WIDTH-1:0] work_r_q, work_r_d, step_r, unused_rotl;
  logic dir_q, dir_d, hit_r;
  rot_step #(.WIDTH(WIDTH)) u_step_r (.word(work_r_q), .rotl1(unused_rotl), .rotr1(step_r));
  assign hit_r = work_r_q == target_q;
  assign dir = dir_q;
`else
  localparam logic [SHW-1:0] K_LAST = SHW'(WIDTH - 1);
  assign dir = 1'b0;
`endif
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign found      = found_q;
  assign shamt      = shamt_q;
  assign shamt_left = shl_q;
  always_comb begin
    state_d  = state_q;
    work_l_d = work_l_q;
    target_d = target_q;
    k_d      = k_q;
    found_d  = found_q;
    shamt_d  = shamt_q;
    shl_d    = shl_q;
`ifdef ROT_FIND_BIDIR_EN
    work_r_d = work_r_q;
    dir_d    = dir_q;
`endif
    if (state_q == IDLE && in_valid) begin
      state_d  = SEARCH;
      work_l_d = orig;
      target_d = rotated;
      k_d      = '0;
`ifdef ROT_FIND_BIDIR_EN
      work_r_d = orig;
`endif
    end else if (state_q == SEARCH) begin
      if (hit_l) begin
        state_d = DONE;
        found_d = 1'b1;
        shamt_d = k_q;
        shl_d   = k_q;
`ifdef ROT_FIND_BIDIR_EN
        dir_d   = 1'b0;
      end else if (hit_r) begin
        state_d = DONE;
        found_d = 1'b1;
        shamt_d = k_q;
        shl_d   = (k_q == '0) ? '0 : SHW'(WIDTH) - k_q;
        dir_d   = 1'b1;
`endif
      end else if (k_q == K_LAST) begin
        state_d = DONE;
        found_d = 1'b0;
        shamt_d = '0;
        shl_d   = '0;
`ifdef ROT_FIND_BIDIR_EN
        dir_d   = 1'b0;
`endif
      end else begin
        work_l_d = step_l;
        k_d      = k_q + SHW'(1);
`ifdef ROT_FIND_BIDIR_EN
        work_r_d = step_r;
`endif
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      work_l_q <= '0;
      target_q <= '0;
      k_q      <= '0;
      found_q  <= 1'b0;
      shamt_q  <= '0;
      shl_q    <= '0;
`ifdef ROT_FIND_BIDIR_EN
      work_r_q <= '0;
      dir_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      work_l_q <= work_l_d;
      target_q <= target_d;
      k_q      <= k_d;
      found_q  <= found_d;
      shamt_q  <= shamt_d;
      shl_q    <= shl_d;
`ifdef ROT_FIND_BIDIR_EN
      work_r_q <= work_r_d;
      dir_q    <= dir_d;
`endif
    end
  end
endmodule

// File: tb/tb_rot_amount_finder.sv
// tb_rot_amount_finder: directed checks of rot_amount_finder at WIDTH = 4.
module tb_rot_amount_finder;
`ifdef ROT_FIND_BIDIR_EN
  localparam int NF_LAT = 4;
  localparam int R1_DIR = 1, R1_SH = 1, R1_SHL = 3, R1_LAT = 3;
`else
  localparam int NF_LAT = 5;
  localparam int R1_DIR = 0, R1_SH = 3, R1_SHL = 3, R1_LAT = 5;
`endif
  logic clk, reset_n, in_valid, in_ready, out_valid, out_ready, found, dir;
  logic [3:0] orig, rotated;
  logic [1:0] shamt, shamt_left;
  int n_tests = 0, n_fail = 0;
  rot_amount_finder #(.WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .orig(orig), .rotated(rotated), .out_valid(out_valid), .out_ready(out_ready),
    .found(found), .dir(dir), .shamt(shamt), .shamt_left(shamt_left)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Issue one request and return at the negedge where out_valid is first seen.
  task automatic do_req(input logic [3:0] o, input logic [3:0] r, input logic hold, output int lat, output logic busy_ok);
    int w = 0;
    while (!in_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1;
    orig = o;
    rotated = r;
    @(posedge clk);
    #1;
    if (hold) begin
      orig = 4'b0101;
      rotated = 4'b0101;
    end else in_valid = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready) busy_ok = 1'b0;
    end
    if (!out_valid) check("timeout", 0, 1);
    in_valid = 1'b0;
  endtask
  task automatic run(input string tag, input logic [3:0] o, input logic [3:0] r,
                     input int ef, input int ed, input int es, input int el, input int elat);
    int lat;
    logic busy_ok;
    do_req(o, r, 1'b0, lat, busy_ok);
    check({tag, "_found"}, found, ef);
    check({tag, "_dir"}, dir, ed);
    check({tag, "_shamt"}, shamt, es);
    check({tag, "_shamt_left"}, shamt_left, el);
    check({tag, "_latency"}, lat, elat);
    @(negedge clk);
    check({tag, "_in_ready_after"}, in_ready, 1);
  endtask
  initial begin
    int lat;
    logic busy_ok;
    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    orig = '0;
    rotated = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_found", found, 0);
    check("rst_dir", dir, 0);
    check("rst_shamt", shamt, 0);
    check("rst_shamt_left", shamt_left, 0);
    reset_n = 1'b1;
    @(negedge clk);
    run("l2", 4'b0001, 4'b0100, 1, 0, 2, 2, 4);
    run("l1", 4'b1011, 4'b0111, 1, 0, 1, 1, 3);
    run("eq", 4'b0101, 4'b0101, 1, 0, 0, 0, 2);
    run("r1", 4'b0001, 4'b1000, 1, R1_DIR, R1_SH, R1_SHL, R1_LAT);
    do_req(4'b0001, 4'b0011, 1'b1, lat, busy_ok);
    check("nf_found", found, 0);
    check("nf_shamt", shamt, 0);
    check("nf_latency", lat, NF_LAT);
    check("nf_busy_not_ready", busy_ok, 1);
    @(negedge clk);
    check("nf_in_ready_after", in_ready, 1);
    out_ready = 1'b0;
    do_req(4'b0010, 4'b1000, 1'b0, lat, busy_ok);
    check("bp_latency", lat, 4);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_found", found, 1);
      check("bp_shamt", shamt, 2);
      check("bp_dir", dir, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    in_valid = 1'b1;
    orig = 4'b0001;
    rotated = 4'b0011;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_found", found, 0);
    check("mid_rst_shamt", shamt, 0);
    check("mid_rst_shamt_left", shamt_left, 0);
    @(negedge clk);
    reset_n = 1'b1;
    busy_ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || !in_ready) busy_ok = 1'b0;
    end
    check("mid_rst_stays_idle", busy_ok, 1);
    run("post_rst", 4'b0001, 4'b0010, 1, 0, 1, 1, 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rot_amount_finder.md
Name: rot_amount_finder

Overview:
- Sequential inverse of the 4-bit left/right rotator. Given an original word and a rotated word, it finds the rotation amount and direction that map one to the other.
- It searches one step per clock, using a single-bit rotate step per cycle.
- It sits downstream of rotator blocks as a checker/decoder and uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 4, data word width in bits (must be >= 2).
- SHW, $clog2(WIDTH), width of the rotation-amount outputs (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- orig  input  WIDTH  unrotated word.
- rotated  input  WIDTH  candidate rotated word.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- found  output  1  a rotation was found.
- dir  output  1  direction of the result: 0 = left, 1 = right.
- shamt  output  SHW  rotation amount in direction dir.
- shamt_left  output  SHW  equivalent left amount, (WIDTH - right amount) mod WIDTH.

Behaviour:
- Reset (asynchronous, while reset_n = 0):
  - state = IDLE.
  - in_ready = 1, out_valid = 0.
  - found = 0, dir = 0, shamt = 0, shamt_left = 0.
  - Internal work and target registers and step counter k cleared.
- Reset mid-operation aborts the search; no result is produced.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: work <= orig, target <= rotated, k <= 0, go to SEARCH.
  - orig and rotated are sampled only in that cycle.
- SEARCH (in_ready = 0, out_valid = 0). Each cycle:
  - If work == target: found <= 1, shamt <= k, shamt_left <= k, dir <= 0, go to DONE.
  - Else if k == WIDTH-1: found <= 0, shamt <= 0, shamt_left <= 0, dir <= 0, go to DONE.
  - Else: work <= rotl1(work), k <= k+1.
- DONE:
  - out_valid = 1; outputs stay stable until out_ready = 1.
  - On the out_valid & out_ready cycle, go to IDLE. A new request is accepted no earlier than the following cycle.
  - in_ready = 0 throughout DONE.
- Latency: accept at cycle t gives out_valid at t+k+2, where k is the first match. Worst case (no match) is t+WIDTH+1.
- Periodic patterns (e.g. 0101, 0000, 1111): the smallest left amount is reported, so equal words always give shamt 0.
- in_valid asserted while the block is busy is ignored; no queueing.
- Result outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
- Macro: ROT_FIND_BIDIR_EN.
- When defined:
  - Each SEARCH cycle compares both rotl(orig,k) and rotr(orig,k) against target.
  - Left wins a tie.
  - dir = 1 when the right path matches first; shamt then holds the right amount, and shamt_left = (WIDTH - k) mod WIDTH.
  - The search ends with not-found after k == WIDTH/2 (both paths checked).
  - Worst-case latency becomes t + WIDTH/2 + 2.
- When undefined:
  - Left-only search as described in Behaviour.
  - dir is tied to 0 and the right-path register is absent.

Decomposition:
- Package rot_pkg holds:
  - enum rot_find_state_t {IDLE, SEARCH, DONE};
  - constant ROT_DEFAULT_WIDTH = 4.
- Sub-module rot_step: combinational, parameter WIDTH, input word, outputs rotl1 and rotr1.
  - Instantiated once for the left path, and once more for the right path when ROT_FIND_BIDIR_EN is defined.

Test Plan (WIDTH = 4):
- orig=0001, rotated=0100, out_ready=1 -> found=1, dir=0, shamt=2, shamt_left=2; out_valid 4 cycles after accept; in_ready returns the cycle after the handshake.
- orig=1011, rotated=0111 -> found=1, shamt=1, shamt_left=1. orig=0101, rotated=0101 -> found=1, shamt=0, out_valid at accept+2.
- orig=0001, rotated=0011 -> found=0, shamt=0, out_valid at accept+5; in_valid held high during SEARCH is not accepted.
- Backpressure: out_ready=0 for 6 cycles after out_valid -> found/shamt/dir stable, in_ready=0; release -> IDLE next cycle.
- reset_n pulsed low during SEARCH -> asynchronous return to reset values, no out_valid; next request completes normally.
- With ROT_FIND_BIDIR_EN: orig=0001, rotated=1000 -> dir=1, shamt=1, shamt_left=3, out_valid at accept+3. orig=0001, rotated=0100 -> dir=0, shamt=2 (tie, left wins).
